// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO sitting behind the UART receiver: captures one
// character per rising edge of rx_done_tick and offers it first-word-fall-through.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rd,
  input  logic                  clr_overrun,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Handshake: the producer offers a character on each rising edge of
  // rx_done_tick (no backpressure, dropped when full); the consumer sees
  // valid = ~empty with rd_data at the head, and rd acts as ready.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  done_q;
  logic                  overrun_q;

  logic wr_en;
  logic rd_eff;
  logic wr_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  assign count  = count_q;
  assign overrun = overrun_q;

  assign wr_en  = rx_done_tick & ~done_q;
  assign rd_eff = rd & ~empty;
  // A read on the same edge frees the slot a full-queue write needs.
  assign wr_ok  = wr_en & (~full | rd_eff);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= rx_done_tick;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Set has priority over clear so a same-edge drop is never lost.
      if (wr_en && full && !rd_eff) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run, compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_done_tick = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rd = 1'b0;
  logic          clr_overrun = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_prev = 1'b0;
  logic          m_ovr = 1'b0;
  logic [DW-1:0] last_read;

  uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd           (rd),
    .clr_overrun  (clr_overrun),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Reference behaviour: one push per rising edge of done, pop when rd and
  // not empty, a push into a full queue without a pop is dropped.
  task automatic model_edge();
    logic wr;
    logic re;
    logic dropped;
    if (!reset) begin
      model_reset();
      return;
    end
    wr = rx_done_tick && !m_prev;
    re = rd && (exp_q.size() > 0);
    dropped = 1'b0;
    if (re) begin
      last_read = exp_q.pop_front();
    end
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(rx_data);
      else dropped = 1'b1;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
    m_prev = rx_done_tick;
  endtask

  task automatic check_state(input string tag);
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, " count"},   32'(count),   32'(exp_q.size()));
    chk({tag, " empty"},   32'(empty),   32'(exp_q.size() == 0));
    chk({tag, " full"},    32'(full),    32'(exp_q.size() == DEPTH));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(head));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic pulse_done(input logic [DW-1:0] d, input string tag);
    rx_data = d;
    rx_done_tick = 1'b1;
    cycle(tag);
    rx_done_tick = 1'b0;
    cycle(tag);
  endtask

  task automatic pop_expect(input logic [DW-1:0] v, input string tag);
    chk({tag, " head"}, 32'(rd_data), 32'(v));
    rd = 1'b1;
    cycle(tag);
    rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      rd = 1'b1;
      cycle(tag);
    end
    rd = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b1;
    #1;
    check_state("reset");
    cycle("idle");
    cycle("idle");

    // Held done level: exactly one write.
    rx_data = 8'hA5;
    rx_done_tick = 1'b1;
    for (int i = 0; i < 20; i++) cycle("held");
    rx_done_tick = 1'b0;
    cycle("held");
    chk("held count", 32'(count), 32'd1);
    pop_expect(8'hA5, "held pop");
    chk("held empty", 32'(empty), 32'd1);

    // Fill, partial drain, refill across the wrap point.
    for (int i = 0; i < 16; i++) pulse_done(DW'(i), "fill");
    chk("fill full", 32'(full), 32'd1);
    chk("fill count", 32'(count), 32'd16);
    for (int i = 0; i < 8; i++) pop_expect(DW'(i), "wrap rd1");
    for (int i = 0; i < 8; i++) pulse_done(DW'(8'h10 + i), "wrap wr");
    for (int i = 0; i < 8; i++) pop_expect(DW'(8'h08 + i), "wrap rd2");
    for (int i = 0; i < 8; i++) pop_expect(DW'(8'h10 + i), "wrap rd3");
    chk("wrap empty", 32'(empty), 32'd1);

    // Overrun on a full queue, then clear.
    for (int i = 0; i < 16; i++) pulse_done(DW'(8'h20 + i), "ovr fill");
    pulse_done(8'hEE, "ovr drop");
    chk("ovr flag", 32'(overrun), 32'd1);
    chk("ovr count", 32'(count), 32'd16);
    chk("ovr head", 32'(rd_data), 32'h20);
    clr_overrun = 1'b1;
    cycle("ovr clr");
    clr_overrun = 1'b0;
    chk("ovr cleared", 32'(overrun), 32'd0);

    // Simultaneous write and read on a full queue.
    rx_data = 8'h55;
    rx_done_tick = 1'b1;
    rd = 1'b1;
    cycle("sim full");
    rd = 1'b0;
    rx_done_tick = 1'b0;
    cycle("sim full");
    chk("sim full count", 32'(count), 32'd16);
    chk("sim full ovr", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_expect(DW'(8'h20 + i), "sim full rd");
    pop_expect(8'h55, "sim full last");
    chk("sim drained", 32'(empty), 32'd1);

    // Simultaneous write and read on an empty queue.
    rx_data = 8'h33;
    rx_done_tick = 1'b1;
    rd = 1'b1;
    cycle("sim empty");
    rd = 1'b0;
    rx_done_tick = 1'b0;
    chk("sim empty count", 32'(count), 32'd1);
    chk("sim empty data", 32'(rd_data), 32'h33);
    cycle("sim empty");
    drain("drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rx_done_tick = ($urandom_range(0, 2) == 0);
      rx_data      = DW'($urandom);
      rd           = (i < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      clr_overrun  = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    rx_done_tick = 1'b0;
    rd = 1'b0;
    clr_overrun = 1'b0;
    cycle("rand end");
    drain("drain2");

    // Asynchronous reset mid-stream, with done held through release.
    for (int i = 0; i < 5; i++) pulse_done(DW'(8'h40 + i), "pre rst");
    chk("pre rst count", 32'(count), 32'd5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    rx_done_tick = 1'b1;
    rx_data = 8'h77;
    #1;
    model_reset();
    check_state("async rst");
    cycle("in rst");
    cycle("in rst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle("post rst");
    chk("post rst count", 32'(count), 32'd1);
    chk("post rst data", 32'(rd_data), 32'h77);
    rx_done_tick = 1'b0;
    cycle("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
